// File: rtl/crypto_arith_pkg.sv
// rtl/crypto_arith_pkg.sv - shared types and sizing helpers for the multi-precision adder
package crypto_arith_pkg;

    localparam int W_DEF     = 32;
    localparam int LIMBS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Limb index width; a two-limb operand still needs one index bit.
    function automatic int idx_width(input int limbs);
        return (limbs <= 2) ? 1 : $clog2(limbs);
    endfunction

endpackage

// File: rtl/add32_cin.sv
// rtl/add32_cin.sv - combinational W-bit adder with carry-in and carry-out
module add32_cin #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign sum  = full[W-1:0];
    assign cout = full[W];

endmodule

// File: rtl/mp_add_ctrl.sv
// rtl/mp_add_ctrl.sv - limb-serial multi-precision add/subtract sequencer over one shared adder
module mp_add_ctrl
    import crypto_arith_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int LIMBS = LIMBS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [W*LIMBS-1:0] a_i,
    input  logic [W*LIMBS-1:0] b_i,
    output logic             busy,
    output logic             done,
    output logic [W*LIMBS-1:0] sum_o,
    output logic             carry_o,
    output logic             zero_o
);

    localparam int N  = W * LIMBS;
    localparam int IW = idx_width(LIMBS);
    localparam logic [IW-1:0] LAST_IDX = IW'(LIMBS - 1);

    state_t        state, state_nxt;
    logic [N-1:0]  opa, opb;
    logic [IW-1:0] idx;
    logic          cin_r;
    logic          zacc;
    logic [W-1:0]  limb_a, limb_b, limb_s;
    logic          limb_c;
    logic          last_limb;
    logic          limb_zero;

    assign limb_a    = opa[int'(idx)*W +: W];
    assign limb_b    = opb[int'(idx)*W +: W];
    assign last_limb = (idx == LAST_IDX);
    assign limb_zero = (limb_s == '0);

    add32_cin #(.W(W)) u_add (
        .a    (limb_a),
        .b    (limb_b),
        .cin  (cin_r),
        .sum  (limb_s),
        .cout (limb_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_limb) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: B is inverted at capture, carry seeded with op_sub.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opa     <= '0;
            opb     <= '0;
            idx     <= '0;
            cin_r   <= 1'b0;
            zacc    <= 1'b0;
            sum_o   <= '0;
            carry_o <= 1'b0;
            zero_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a_i;
                        opb   <= op_sub ? ~b_i : b_i;
                        cin_r <= op_sub;
                        idx   <= '0;
                        zacc  <= 1'b1;
                    end
                end
                RUN: begin
                    sum_o[int'(idx)*W +: W] <= limb_s;
                    cin_r <= limb_c;
                    zacc  <= zacc & limb_zero;
                    // Flags are published as RUN ends so they are already valid while done is high.
                    if (last_limb) begin
                        carry_o <= limb_c;
                        zero_o  <= zacc & limb_zero;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mp_add_ctrl.sv
// tb/tb_mp_add_ctrl.sv - directed and random checks of mp_add_ctrl against a 256-bit arithmetic model
module tb_mp_add_ctrl;

    localparam int W     = 32;
    localparam int LIMBS = 8;
    localparam int N     = W * LIMBS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         op_sub;
    logic [N-1:0] a_i, b_i;
    logic         busy, done;
    logic [N-1:0] sum_o;
    logic         carry_o, zero_o;

    int total = 0;
    int bad   = 0;

    mp_add_ctrl #(.W(W), .LIMBS(LIMBS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op_sub  (op_sub),
        .a_i     (a_i),
        .b_i     (b_i),
        .busy    (busy),
        .done    (done),
        .sum_o   (sum_o),
        .carry_o (carry_o),
        .zero_o  (zero_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic sub, input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] s, output logic c, output logic z);
        if (sub) begin
            s = a - b;
            c = (a >= b);
        end else begin
            {c, s} = {1'b0, a} + {1'b0, b};
        end
        z = (s == '0);
    endfunction

    function automatic logic [N-1:0] rand_wide();
        logic [N-1:0] v;
        for (int i = 0; i < LIMBS; i++) v[i*W +: W] = $urandom;
        return v;
    endfunction

    task automatic check_result(input string tag, input logic sub, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] es;
        logic ec, ez;
        model(sub, a, b, es, ec, ez);
        chk({tag, ".sum"}, sum_o, es);
        chk({tag, ".carry"}, N'(carry_o), N'(ec));
        chk({tag, ".zero"}, N'(zero_o), N'(ez));
    endtask

    // Issue one op from IDLE, wait for done, check result; timing checks optional.
    task automatic do_op(input string tag, input logic sub, input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit check_timing);
        int lat, bcnt;
        bit seen;
        @(negedge clk);
        start = 1'b1; op_sub = sub; a_i = a; b_i = b;
        @(posedge clk);
        #1;
        start = 1'b0; op_sub = ~sub; a_i = ~a; b_i = rand_wide();
        lat = 0; bcnt = 0; seen = 0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (done) seen = 1;
        end
        if (!seen) begin
            chk({tag, ".timeout"}, N'(0), N'(1));
        end else begin
            if (check_timing) begin
                chk({tag, ".latency"}, N'(lat), N'(LIMBS + 1));
                chk({tag, ".busy_cycles"}, N'(bcnt), N'(LIMBS));
                chk({tag, ".busy_in_done"}, N'(busy), N'(0));
            end
            check_result(tag, sub, a, b);
        end
    endtask

    initial begin
        logic [N-1:0] ra, rb, fa, fb;
        logic         rs;
        int           dcnt;

        rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a_i = '0; b_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", N'(busy), N'(0));
        chk("rst.done", N'(done), N'(0));
        chk("rst.sum", sum_o, N'(0));
        chk("rst.carry", N'(carry_o), N'(0));
        chk("rst.zero", N'(zero_o), N'(0));
        rst_n = 1'b1;

        // Carry ripples through every limb.
        do_op("ripple", 1'b0, {N{1'b1}}, N'(1), 1'b1);
        chk("ripple.zero_direct", N'(zero_o), N'(1));

        do_op("sub_nb", 1'b1, N'(5), N'(3), 1'b1);
        chk("sub_nb.limb0", N'(sum_o[W-1:0]), N'(2));

        do_op("sub_b", 1'b1, N'(3), N'(5), 1'b1);
        chk("sub_b.limb0", N'(sum_o[W-1:0]), N'(32'hFFFF_FFFE));

        // start held through RUN and DONE must not queue a second operation.
        fa = rand_wide(); fb = rand_wide();
        @(negedge clk);
        start = 1'b1; op_sub = 1'b0; a_i = fa; b_i = fb;
        dcnt = 0;
        for (int k = 1; k <= LIMBS + 1; k++) begin
            @(posedge clk);
            #1;
            a_i = rand_wide(); b_i = rand_wide(); op_sub = $urandom_range(0, 1);
            @(negedge clk);
            if (done) begin
                dcnt++;
                chk("spam.done_cycle", N'(k), N'(LIMBS + 1));
                check_result("spam", 1'b0, fa, fb);
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("spam.idle_busy", N'(busy), N'(0));
        chk("spam.idle_done", N'(done), N'(0));
        @(negedge clk);
        chk("spam.idle_busy2", N'(busy), N'(0));
        chk("spam.done_count", N'(dcnt), N'(1));
        check_result("spam.hold", 1'b0, fa, fb);

        // Reset during the 4th RUN cycle discards the operation.
        @(negedge clk);
        start = 1'b1; op_sub = 1'b0; a_i = rand_wide(); b_i = rand_wide();
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst.busy", N'(busy), N'(0));
        chk("midrst.done", N'(done), N'(0));
        chk("midrst.sum", sum_o, N'(0));
        chk("midrst.carry", N'(carry_o), N'(0));
        dcnt = 0;
        repeat (LIMBS + 2) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("midrst.quiet", N'(dcnt), N'(0));
        do_op("post_rst", 1'b0, N'(16'h1234), N'(1), 1'b1);
        chk("post_rst.limb0", N'(sum_o[W-1:0]), N'(32'h1235));

        for (int i = 0; i < 1000; i++) begin
            ra = rand_wide();
            rb = ($urandom_range(0, 15) == 0) ? ra : rand_wide();
            if ($urandom_range(0, 15) == 0) rb = ~ra;
            rs = $urandom_range(0, 1);
            do_op("rand", rs, ra, rb, (i % 50) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mp_add_ctrl.md
Name: mp_add_ctrl

Overview:
- Multi-precision add/subtract sequencer. It time-shares one 32-bit ripple adder limb-by-limb to produce a LIMBS×W-bit sum or difference.
- Sits between the crypto datapath (bignum/field arithmetic) and the shared adder. It owns operand capture, carry chaining, limb scheduling and the start/done handshake.

Parameters:
- W, 32, limb width in bits (must match the adder width).
- LIMBS, 8, number of limbs per operand (operand width = W*LIMBS; must be ≥ 2).

Ports:
- clk, input, 1, single clock; all state changes on its rising edge.
- rst_n, input, 1, synchronous active-low reset.
- start, input, 1, request a new operation; accepted only in IDLE.
- op_sub, input, 1, sampled with start. 0 = A+B, 1 = A−B.
- a_i, input, W*LIMBS, operand A, limb 0 = bits [W-1:0]; sampled with start.
- b_i, input, W*LIMBS, operand B; sampled with start.
- busy, output, 1, high while limbs are being processed (RUN).
- done, output, 1, one-cycle pulse when the result is complete.
- sum_o, output, W*LIMBS, result register; valid from the done cycle until the next accepted start.
- carry_o, output, 1, final carry. Add: carry out of the top limb. Sub: 1 = no borrow (A ≥ B), 0 = borrow.
- zero_o, output, 1, 1 when the full result is all zeros; valid with done.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; busy=0, done=0, sum_o=0, carry_o=0, zero_o=0; limb index=0. Reset overrides everything, including mid-RUN; the partial result is discarded and no done is issued.
- States are IDLE, RUN, DONE.
- IDLE, start=1: capture a_i and b_i into operand registers. If op_sub=1, capture B bitwise inverted. Set carry register = op_sub, index=0, zero accumulator=1, go to RUN.
- IDLE, start=0: hold all outputs.
- RUN, each cycle:
  - Adder input is operand limb[index], (B-prime) limb[index], carry register.
  - The W-bit result is written to sum_o limb[index]; the adder carry-out goes to the carry register.
  - Zero accumulator &= (limb result == 0).
  - index increments.
  - When index == LIMBS-1 on this cycle, go to DONE.
- DONE, one cycle: done=1, busy=0; carry_o = carry register, zero_o = zero accumulator. Next state is IDLE.
- busy=1 exactly in RUN. done=1 exactly in DONE.
- Latency: start sampled at edge t → busy during cycles t+1..t+LIMBS → done high in cycle t+LIMBS+1.
  - Back-to-back: the next start is accepted at the earliest in the cycle after done (IDLE).
  - Throughput is one op per LIMBS+2 cycles.
- start is ignored in RUN and DONE; it is not queued. a_i, b_i and op_sub are don't-care outside the accepting cycle.
- sum_o limbs update progressively during RUN; consumers use sum_o only on or after done. carry_o and zero_o hold their last values until the next DONE.
- Width rules: all limb arithmetic is modulo 2^W with a 1-bit carry. There is no saturation. Overflow is reported only via carry_o. Subtraction wraps modulo 2^(W*LIMBS).
- The index counter is ceil(log2(LIMBS)) bits and never wraps past LIMBS-1.

Decomposition:
- Shared package (crypto_arith_pkg):
  - Localparams W and LIMBS defaults.
  - State enum {IDLE, RUN, DONE}.
  - Limb index width function (clog2).
- One sub-module: add32_cin, a combinational W-bit adder with carry-in and carry-out. It is the shared adder resource, instantiated once. The controller holds no other arithmetic.

Test Plan:
- Carry ripple across all limbs. A = 2^256−1 (all 0xFFFFFFFF), B = 1, add → sum_o = 0, carry_o = 1, zero_o = 1; done exactly 9 cycles after the start edge; busy high 8 cycles.
- Subtract, no borrow. A = 0x…0005 (limb0 = 5, rest 0), B = 3, sub → sum_o limb0 = 2, other limbs 0, carry_o = 1, zero_o = 0.
- Subtract, borrow. A = 3, B = 5, sub → sum_o = 2^256−2 (limb0 = 0xFFFFFFFE, others 0xFFFFFFFF), carry_o = 0.
- start pulsed high on every cycle of RUN and DONE after an initial accepted add → exactly one done; the result matches the first operands; the second op starts only from IDLE.
- rst_n driven low at the 4th RUN cycle → next cycle busy = 0, done = 0, sum_o = 0, carry_o = 0. A subsequent add of 0x1234 + 0x1 completes normally (limb0 = 0x1235).
- Random regression: 1000 random A, B, op_sub values against a 256-bit reference model → sum_o, carry_o and zero_o match on every done.
